// File: rtl/uart_rx_param.sv
// Parametrised UART receive engine: input synchroniser, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, break detection and a valid/ready output
// stage that reports dropped frames through an overrun flag.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] CNT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] CNT_S0    = SW'(M - 1);
  localparam logic [SW-1:0] CNT_S1    = SW'(M);
  localparam logic [SW-1:0] CNT_S2    = SW'(M + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  // Parity check: odd mode errs on an even total, even mode errs on an odd total.
  function automatic logic f_parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY_MODE == 1) begin
      return ~x;
    end else begin
      return x;
    end
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SW-1:0]          r_sample_cnt, w_cnt_nxt;
  logic [BW-1:0]          r_bit_cnt, w_bit_nxt;
  logic [1:0]             r_smp;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_err, r_frm_err, r_all_zero;
  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_valid, r_pe, r_fe, r_brk, r_ov;

  logic w_rx_s, w_maj, w_mid, w_wrap, w_counting;
  logic w_clear, w_shift_en, w_par_en, w_stop_en, w_commit;
  logic w_fe_fin, w_brk_fin;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_maj      = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
  assign w_mid      = tick && (r_sample_cnt == CNT_S2);
  assign w_wrap     = tick && (r_sample_cnt == CNT_LAST);
  assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_fe_fin   = r_frm_err | ~w_maj;
  assign w_brk_fin  = w_fe_fin & r_all_zero & ~w_maj;

  // Synchroniser for the asynchronous line; presets to idle-high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= {SW{1'b0}};
      r_bit_cnt    <= {BW{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_cnt_nxt;
      r_bit_cnt    <= w_bit_nxt;
    end
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_sample_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_clear     = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    w_commit    = 1'b0;
    if (w_counting && tick) begin
      if (r_sample_cnt == CNT_LAST) begin
        w_cnt_nxt = {SW{1'b0}};
      end else begin
        w_cnt_nxt = r_sample_cnt + 1'b1;
      end
    end else begin
      w_cnt_nxt = r_sample_cnt;
    end
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = {SW{1'b0}};
          w_bit_nxt   = {BW{1'b0}};
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_mid && w_maj) begin
          w_state_nxt = S_IDLE;
        end else if (w_wrap) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        w_shift_en = w_mid;
        if (w_wrap) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_nxt = {BW{1'b0}};
            if (PARITY_MODE != 0) begin
              w_state_nxt = S_PARITY;
            end else begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        w_par_en = w_mid;
        if (w_wrap) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_mid) begin
          w_stop_en = 1'b1;
          if (r_bit_cnt == STOP_LAST) begin
            // Commit mid-bit so the next start edge is never missed.
            w_commit = 1'b1;
            if (w_fe_fin) begin
              w_state_nxt = S_WAIT_HIGH;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_STOP;
          end
        end else if (w_wrap) begin
          w_bit_nxt = r_bit_cnt + 1'b1;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        // A line still held low must not look like a fresh start bit.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the two early samples of the majority vote.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_smp <= 2'b00;
    end else begin
      if (tick && (r_sample_cnt == CNT_S0)) r_smp[0] <= w_rx_s;
      if (tick && (r_sample_cnt == CNT_S1)) r_smp[1] <= w_rx_s;
    end
  end

  // Frame datapath: shift register and per-frame error accumulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= {DATA_BITS{1'b0}};
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_all_zero <= 1'b1;
    end else if (w_clear) begin
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_all_zero <= 1'b1;
    end else begin
      if (w_shift_en) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (w_par_en) r_par_err <= f_parity_bad(r_shift, w_maj);
      if (w_stop_en) r_frm_err <= r_frm_err | ~w_maj;
      if (w_shift_en || w_par_en || w_stop_en) r_all_zero <= r_all_zero & ~w_maj;
    end
  end

  // Output holding register with valid/ready handshake and overrun tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= {DATA_BITS{1'b0}};
      r_valid    <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_brk      <= 1'b0;
      r_ov       <= 1'b0;
    end else if (w_commit) begin
      if (!r_valid || data_ready) begin
        r_data_out <= r_shift;
        r_pe       <= r_par_err;
        r_fe       <= w_fe_fin;
        r_brk      <= w_brk_fin;
        r_valid    <= 1'b1;
        r_ov       <= 1'b0;
      end else begin
        r_ov <= 1'b1;
      end
    end else if (r_valid && data_ready) begin
      r_valid <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign break_det  = r_brk;
  assign overrun    = r_ov;

endmodule
